// File: rtl/pipeline_sched.sv
// pipeline_sched: stall/flush sequencer for the 4-register MISC-V core.
// It tracks the instructions in EX and MEM and detects RAW hazards against
// the instruction in ID. It freezes the pipeline while a data-memory access
// is outstanding and runs a two-cycle kill sequence after a taken branch.
// It drives the PC enable and every stage-register enable, bubble and flush.
//
// Optional feature macro: PIPE_SCHED_FORWARD_EN
//   defined   : the datapath forwards EX/MEM results into EX, so only a load
//               in EX feeding the ID instruction causes a stall (1 cycle).
//   undefined : any valid writer in EX or MEM that matches a source register
//               of the ID instruction stalls ID.
//
// Handshake: mem_req is raised whenever a load/store sits in MEM and stays
// high until a cycle with mem_ready=1, or until the wait times out. That
// cycle is the completion cycle and the pipeline advances in it. mem_req
// is a level, not a pulse, and the memory may accept it in its first cycle.
//
// dbg_state exposes the FSM state (0=RUN, 1=MEM_WAIT, 2=FLUSH).

module pipeline_sched #(
  parameter int REG_ADDR_W  = 2,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  ex_branch_taken,
  input  logic                  mem_ready,
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  ifid_flush,
  output logic                  idex_bubble,
  output logic                  exmem_en,
  output logic                  memwb_en,
  output logic                  mem_req,
  output logic                  mem_err,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [1:0]            dbg_state
);

  // The wait counter only needs to hold 0 .. MEM_TIMEOUT-1.
  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_e;

  // Status the sequencer keeps for an instruction in a tracked stage.
  typedef struct packed {
    logic                  v;
    logic [REG_ADDR_W-1:0] rd;
    logic                  we;
    logic                  ld;
    logic                  st;
  } stage_t;

  state_e              state_q, state_d;
  stage_t              ex_q, ex_d;
  stage_t              mem_q, mem_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                mem_err_q;
  logic [CNT_W-1:0]    stall_q;
  logic                started_q;

  logic                match_rs1;
  logic                match_rs2;
  logic                hazard;
  logic                mem_busy;
  logic                branch_ex;
  logic                issue;
  logic                err_set;

`ifdef PIPE_SCHED_FORWARD_EN
  // Forwarding covers every ALU result; only a load still in EX is too late.
  assign match_rs1 = ex_q.v & ex_q.we & ex_q.ld & (ex_q.rd == id_rs1);
  assign match_rs2 = ex_q.v & ex_q.we & ex_q.ld & (ex_q.rd == id_rs2);
`else
  // No forwarding: any pending writer in EX or MEM blocks the reader. WB is
  // left out because the register file writes through to the read ports.
  assign match_rs1 = (ex_q.v  & ex_q.we  & (ex_q.rd  == id_rs1)) |
                     (mem_q.v & mem_q.we & (mem_q.rd == id_rs1));
  assign match_rs2 = (ex_q.v  & ex_q.we  & (ex_q.rd  == id_rs2)) |
                     (mem_q.v & mem_q.we & (mem_q.rd == id_rs2));
`endif

  assign hazard    = id_valid & ((id_use_rs1 & match_rs1) | (id_use_rs2 & match_rs2));
  assign mem_busy  = mem_q.v & (mem_q.ld | mem_q.st);
  assign branch_ex = ex_q.v & ex_branch_taken;

  // Next state and stage controls. "issue" marks a cycle in which the memory
  // side is not blocking, so the branch/hazard/advance decision applies.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    err_set     = 1'b0;
    issue       = 1'b0;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    if (started_q) begin
      unique case (state_q)
        ST_RUN: begin
          if (mem_busy && !mem_ready) begin
            // Freeze everything; this cycle is the first stall cycle.
            state_d    = ST_MEM_WAIT;
            wait_cnt_d = '0;
          end else begin
            issue = 1'b1;
          end
        end
        ST_MEM_WAIT: begin
          if (mem_ready) begin
            issue   = 1'b1;
            state_d = ST_RUN;
          end else if (wait_cnt_q == WAIT_LAST) begin
            // Give up on the memory: flag it and let the pipeline move on.
            issue   = 1'b1;
            err_set = 1'b1;
            state_d = ST_RUN;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end
        ST_FLUSH: begin
          // Kill the wrong-path word the synchronous I-mem returned; ID is
          // being discarded, so its hazards do not matter.
          pc_en       = 1'b1;
          ifid_en     = 1'b1;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          exmem_en    = 1'b1;
          memwb_en    = 1'b1;
          state_d     = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase

      if (issue) begin
        if (branch_ex) begin
          // A branch held during a memory wait is acted on here as well.
          pc_en       = 1'b1;
          ifid_en     = 1'b1;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          exmem_en    = 1'b1;
          memwb_en    = 1'b1;
          state_d     = ST_FLUSH;
        end else if (hazard) begin
          idex_bubble = 1'b1;
          exmem_en    = 1'b1;
          memwb_en    = 1'b1;
        end else begin
          pc_en    = 1'b1;
          ifid_en  = 1'b1;
          exmem_en = 1'b1;
          memwb_en = 1'b1;
        end
      end
    end
  end

  // Tracked-stage shift: ID (or a bubble) into EX, EX into MEM on advance.
  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    if (exmem_en) begin
      mem_d = ex_q;
      if (idex_bubble) begin
        ex_d = '0;
      end else begin
        ex_d = {id_valid, id_rd, id_reg_write, id_mem_read, id_mem_write};
      end
    end
  end

  // FSM, tracked stages and wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      ex_q       <= '0;
      mem_q      <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ex_q       <= ex_d;
      mem_q      <= mem_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Hold every control low until the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started_q <= 1'b0;
    end else begin
      started_q <= 1'b1;
    end
  end

  // Sticky timeout flag; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_err_q <= 1'b0;
    end else if (err_set) begin
      mem_err_q <= 1'b1;
    end
  end

  // Saturating count of cycles in which the PC did not advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (started_q && !pc_en && (stall_q != CNT_MAX)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign mem_req      = started_q & ((state_q == ST_MEM_WAIT) | mem_busy);
  assign mem_err      = mem_err_q;
  assign stall_cycles = stall_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_pipeline_sched.sv
// Directed bench for pipeline_sched (default build, forwarding disabled).
// Control outputs are compared as one vector:
//   {pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en, memwb_en, mem_req}
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge. The stall counter is narrowed to 5 bits so saturation
// is reachable in a short run.

module tb_pipeline_sched;

  localparam int RW = 2;
  localparam int TO = 15;
  localparam int CW = 5;

  localparam logic [6:0] P_OFF   = 7'b0000000;
  localparam logic [6:0] P_RUN   = 7'b1100110;
  localparam logic [6:0] P_HAZ   = 7'b0001110;
  localparam logic [6:0] P_BR    = 7'b1111110;
  localparam logic [6:0] P_BRREQ = 7'b1111111;
  localparam logic [6:0] P_FRZ   = 7'b0000001;
  localparam logic [6:0] P_REL   = 7'b1100111;

  // ---------------- clock / reset / DUT ----------------
  logic          clk;
  logic          rst_n;
  logic          id_valid;
  logic [RW-1:0] id_rs1;
  logic [RW-1:0] id_rs2;
  logic          id_use_rs1;
  logic          id_use_rs2;
  logic [RW-1:0] id_rd;
  logic          id_reg_write;
  logic          id_mem_read;
  logic          id_mem_write;
  logic          ex_branch_taken;
  logic          mem_ready;
  logic          pc_en;
  logic          ifid_en;
  logic          ifid_flush;
  logic          idex_bubble;
  logic          exmem_en;
  logic          memwb_en;
  logic          mem_req;
  logic          mem_err;
  logic [CW-1:0] stall_cycles;
  logic [1:0]    dbg_state;

  wire [6:0] ctl = {pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en, memwb_en, mem_req};

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipeline_sched #(
    .REG_ADDR_W (RW),
    .MEM_TIMEOUT(TO),
    .CNT_W      (CW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_valid       (id_valid),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_use_rs1     (id_use_rs1),
    .id_use_rs2     (id_use_rs2),
    .id_rd          (id_rd),
    .id_reg_write   (id_reg_write),
    .id_mem_read    (id_mem_read),
    .id_mem_write   (id_mem_write),
    .ex_branch_taken(ex_branch_taken),
    .mem_ready      (mem_ready),
    .pc_en          (pc_en),
    .ifid_en        (ifid_en),
    .ifid_flush     (ifid_flush),
    .idex_bubble    (idex_bubble),
    .exmem_en       (exmem_en),
    .memwb_en       (memwb_en),
    .mem_req        (mem_req),
    .mem_err        (mem_err),
    .stall_cycles   (stall_cycles),
    .dbg_state      (dbg_state)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic drv_id(input logic v, input logic [RW-1:0] rs1, input logic u1,
                        input logic [RW-1:0] rs2, input logic u2, input logic [RW-1:0] rd,
                        input logic we, input logic ld, input logic st);
    id_valid     = v;
    id_rs1       = rs1;
    id_use_rs1   = u1;
    id_rs2       = rs2;
    id_use_rs2   = u2;
    id_rd        = rd;
    id_reg_write = we;
    id_mem_read  = ld;
    id_mem_write = st;
  endtask

  task automatic idle_id();
    drv_id(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runaway guard.
  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst_n           = 1'b0;
    ex_branch_taken = 1'b0;
    mem_ready       = 1'b1;
    idle_id();
    tick();
    tick();
    settle();
    chk("rst_ctl", ctl, P_OFF);
    chk("rst_stall", stall_cycles, 0);
    chk("rst_err", mem_err, 0);
    chk("rst_state", dbg_state, 0);
    tick();
    rst_n = 1'b1;
    settle();
    chk("rel_ctl_before_clk", ctl, P_OFF);
    tick();
    settle();
    chk("rel_ctl_after_clk", ctl, P_RUN);
    chk("rel_stall", stall_cycles, 0);
    tick();

    // RAW behind an ALU writer in EX: two stall cycles.
    drv_id(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0);
    settle(); chk("raw_w1", ctl, P_RUN); tick();
    drv_id(1'b1, 2'd1, 1'b1, 2'd0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0);
    settle(); chk("raw_stall1", ctl, P_HAZ); tick();
    settle(); chk("raw_stall2", ctl, P_HAZ); tick();
    settle(); chk("raw_go", ctl, P_RUN); chk("raw_cnt", stall_cycles, 2); tick();
    // Unrelated rs2 after the writer left; then sources with use bits clear.
    drv_id(1'b1, 2'd3, 1'b0, 2'd1, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0);
    settle(); chk("nodep_rs2", ctl, P_RUN); tick();
    drv_id(1'b1, 2'd3, 1'b0, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    settle(); chk("use_bits_clear", ctl, P_RUN); tick();
    // Writer of r3 now in MEM only: one stall on rs2.
    drv_id(1'b1, 2'd0, 1'b0, 2'd3, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    settle(); chk("mem_raw_stall", ctl, P_HAZ); tick();
    settle(); chk("mem_raw_go", ctl, P_RUN); chk("mem_raw_cnt", stall_cycles, 3); tick();
    idle_id();
    settle(); chk("drain", ctl, P_RUN); tick();
    tick();

    // Taken branch with a simultaneous hazard: branch wins, then FLUSH.
    drv_id(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0);
    settle(); chk("br_pre", ctl, P_RUN); tick();
    drv_id(1'b1, 2'd1, 1'b1, 2'd0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0);
    ex_branch_taken = 1'b1;
    settle(); chk("br_run", ctl, P_BR); tick();
    settle(); chk("br_flush", ctl, P_BR); chk("br_state_flush", dbg_state, 2); tick();
    settle(); chk("br_after", ctl, P_RUN); chk("br_state_run", dbg_state, 0);
    chk("br_cnt", stall_cycles, 3); tick();
    ex_branch_taken = 1'b0;
    idle_id();
    tick();
    tick();

    // Load waits 3 cycles in MEM, completes on the 4th.
    drv_id(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0);
    settle(); chk("mw_load_id", ctl, P_RUN); tick();
    idle_id();
    mem_ready = 1'b0;
    settle(); chk("mw_load_ex", ctl, P_RUN); tick();
    settle(); chk("mw_frz1", ctl, P_FRZ); tick();
    settle(); chk("mw_frz2", ctl, P_FRZ); chk("mw_state", dbg_state, 1); tick();
    settle(); chk("mw_frz3", ctl, P_FRZ); tick();
    mem_ready = 1'b1;
    settle(); chk("mw_release", ctl, P_REL); tick();
    settle(); chk("mw_after", ctl, P_RUN); chk("mw_cnt", stall_cycles, 6);
    chk("mw_state_run", dbg_state, 0); tick();

    // Store accepted in its first MEM cycle: no wait state.
    drv_id(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    settle(); chk("zw_id", ctl, P_RUN); tick();
    idle_id();
    settle(); chk("zw_ex", ctl, P_RUN); tick();
    settle(); chk("zw_mem", ctl, P_REL); tick();
    settle(); chk("zw_state", dbg_state, 0); chk("zw_cnt", stall_cycles, 6); tick();

    // Load stalled in MEM with a taken branch in EX: freeze, then flush.
    drv_id(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0);
    settle(); chk("sim_load", ctl, P_RUN); tick();
    drv_id(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    mem_ready = 1'b0;
    settle(); chk("sim_br_id", ctl, P_RUN); tick();
    idle_id();
    ex_branch_taken = 1'b1;
    settle(); chk("sim_frz1", ctl, P_FRZ); tick();
    settle(); chk("sim_frz2", ctl, P_FRZ); chk("sim_state_wait", dbg_state, 1); tick();
    mem_ready = 1'b1;
    settle(); chk("sim_release_br", ctl, P_BRREQ); tick();
    ex_branch_taken = 1'b0;
    settle(); chk("sim_flush", ctl, P_BR); chk("sim_state_flush", dbg_state, 2); tick();
    settle(); chk("sim_after", ctl, P_RUN); chk("sim_cnt", stall_cycles, 8); tick();

    // Memory never answers: 15 frozen cycles, forced release, sticky error.
    drv_id(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0);
    settle(); chk("tmo_load", ctl, P_RUN); tick();
    idle_id();
    mem_ready = 1'b0;
    settle(); chk("tmo_load_ex", ctl, P_RUN); tick();
    for (int i = 0; i < TO; i++) begin
      settle(); chk($sformatf("tmo_frz%0d", i), ctl, P_FRZ); tick();
    end
    settle(); chk("tmo_release", ctl, P_REL); chk("tmo_err_before", mem_err, 0); tick();
    settle(); chk("tmo_err", mem_err, 1); chk("tmo_state", dbg_state, 0);
    chk("tmo_after", ctl, P_RUN); chk("tmo_cnt", stall_cycles, 23); tick();
    settle(); chk("tmo_err_sticky", mem_err, 1); tick();

    // Another wait drives the 5-bit counter into saturation, then reset
    // arrives mid-wait.
    drv_id(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0);
    settle(); chk("rs_load", ctl, P_RUN); tick();
    idle_id();
    settle(); chk("rs_load_ex", ctl, P_RUN); tick();
    for (int i = 0; i < 10; i++) begin
      tick();
    end
    settle();
    chk("sat_cnt", stall_cycles, 31);
    chk("rs_frz", ctl, P_FRZ);
    chk("rs_state_wait", dbg_state, 1);
    chk("rs_err_held", mem_err, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rs_async_ctl", ctl, P_OFF);
    chk("rs_async_state", dbg_state, 0);
    chk("rs_async_cnt", stall_cycles, 0);
    chk("rs_async_err", mem_err, 0);
    tick();
    tick();
    rst_n = 1'b1;
    settle(); chk("rs_rel_before_clk", ctl, P_OFF); tick();
    settle(); chk("rs_rel_after_clk", ctl, P_RUN); chk("rs_rel_cnt", stall_cycles, 0); tick();

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
